// File: rtl/uart_pkg.sv
// Shared definitions for the UART Avalon-MM controller: register map,
// STATUS bit positions and CTRL field layout.
package uart_pkg;

   localparam logic [1:0] UART_ADDR_RXDATA = 2'd0;
   localparam logic [1:0] UART_ADDR_TXDATA = 2'd1;
   localparam logic [1:0] UART_ADDR_STATUS = 2'd2;
   localparam logic [1:0] UART_ADDR_CTRL   = 2'd3;

   localparam int UART_ST_RX_FULL  = 0;
   localparam int UART_ST_TX_EMPTY = 1;
   localparam int UART_ST_RX_OVR   = 2;
   localparam int UART_ST_TX_DROP  = 3;

   localparam int UART_DIV_W       = 16;
   localparam int UART_CTRL_RX_IE  = 16;
   localparam int UART_CTRL_TX_IE  = 17;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample tick generator: reloadable down-counter, registered
// one-cycle tick every DIV+1 clocks.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter logic [UART_DIV_W-1:0] DEFAULT_DIV = 16'd26
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [UART_DIV_W-1:0] div_i,
   input  logic                  reload_i,
   output logic                  tick_o
);

   logic [UART_DIV_W-1:0] cnt_q;
   logic                  tick_q;

   // A reload restarts the period and swallows any tick due this cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= DEFAULT_DIV;
         tick_q <= 1'b0;
      end else if (reload_i) begin
         cnt_q  <= div_i;
         tick_q <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q  <= div_i;
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_q - 1'b1;
         tick_q <= 1'b0;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/uart_avmm_ctrl.sv
// Avalon-MM register front end and TX/RX byte buffering for uart_core.
// Optional interrupt output enabled by defining UART_CTRL_IRQ_EN.
module uart_avmm_ctrl
   import uart_pkg::*;
#(
   parameter logic [UART_DIV_W-1:0] DEFAULT_DIV = 16'd26
) (
   input  logic        clk,
   input  logic        reset_n,
`ifdef UART_CTRL_IRQ_EN
   output logic        irq,
`endif
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        core_tx_valid,
   input  logic        core_tx_ready,
   output logic [7:0]  core_tx_data,
   input  logic        core_rx_valid,
   input  logic [7:0]  core_rx_data,
   output logic        baud_tick
);

   logic [7:0]            rx_hold_q, rx_hold_d;
   logic                  rx_full_q, rx_full_d;
   logic                  rx_ovr_q, rx_ovr_d;
   logic [7:0]            tx_hold_q, tx_hold_d;
   logic                  tx_full_q, tx_full_d;
   logic                  tx_drop_q, tx_drop_d;
   logic [UART_DIV_W-1:0] div_q, div_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rx_ie_q, rx_ie_d;
   logic                  tx_ie_q, tx_ie_d;

   logic rd_rx, wr_tx, wr_st, wr_ctrl, tx_hs;

   assign rd_rx   = avs_read  && (avs_address == UART_ADDR_RXDATA);
   assign wr_tx   = avs_write && (avs_address == UART_ADDR_TXDATA);
   assign wr_st   = avs_write && (avs_address == UART_ADDR_STATUS);
   assign wr_ctrl = avs_write && (avs_address == UART_ADDR_CTRL);
   assign tx_hs   = tx_full_q && core_tx_ready;

   always_comb begin
      rx_hold_d = rx_hold_q;
      rx_full_d = rx_full_q;
      rx_ovr_d  = rx_ovr_q;
      tx_hold_d = tx_hold_q;
      tx_full_d = tx_full_q;
      tx_drop_d = tx_drop_q;
      div_d     = div_q;
      rdata_d   = rdata_q;
      rx_ie_d   = rx_ie_q;
      tx_ie_d   = tx_ie_q;

      // Readback is built from current state, so same-cycle writes are unseen.
      if (avs_read) begin
         unique case (avs_address)
            UART_ADDR_RXDATA: rdata_d = {24'b0, rx_hold_q};
            UART_ADDR_TXDATA: rdata_d = '0;
            UART_ADDR_STATUS: rdata_d = {28'b0, tx_drop_q, rx_ovr_q,
                                         !tx_full_q, rx_full_q};
            UART_ADDR_CTRL:   rdata_d = {14'b0, tx_ie_q, rx_ie_q, div_q};
         endcase
      end

      if (wr_st) begin
         if (avs_writedata[UART_ST_RX_OVR])  rx_ovr_d  = 1'b0;
         if (avs_writedata[UART_ST_TX_DROP]) tx_drop_d = 1'b0;
      end

      if (tx_hs) tx_full_d = 1'b0;
      if (wr_tx) begin
         if (!tx_full_q || tx_hs) begin
            tx_hold_d = avs_writedata[7:0];
            tx_full_d = 1'b1;
         end else begin
            tx_drop_d = 1'b1;
         end
      end

      // A read that drains the buffer makes room for a coincident byte.
      if (rd_rx) rx_full_d = 1'b0;
      if (core_rx_valid) begin
         if (!rx_full_q || rd_rx) begin
            rx_hold_d = core_rx_data;
            rx_full_d = 1'b1;
         end else begin
            rx_ovr_d  = 1'b1;
         end
      end

      if (wr_ctrl) begin
         div_d = avs_writedata[UART_DIV_W-1:0];
`ifdef UART_CTRL_IRQ_EN
         rx_ie_d = avs_writedata[UART_CTRL_RX_IE];
         tx_ie_d = avs_writedata[UART_CTRL_TX_IE];
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_hold_q <= '0;
         rx_full_q <= 1'b0;
         rx_ovr_q  <= 1'b0;
         tx_hold_q <= '0;
         tx_full_q <= 1'b0;
         tx_drop_q <= 1'b0;
         div_q     <= DEFAULT_DIV;
         rdata_q   <= '0;
         rx_ie_q   <= 1'b0;
         tx_ie_q   <= 1'b0;
      end else begin
         rx_hold_q <= rx_hold_d;
         rx_full_q <= rx_full_d;
         rx_ovr_q  <= rx_ovr_d;
         tx_hold_q <= tx_hold_d;
         tx_full_q <= tx_full_d;
         tx_drop_q <= tx_drop_d;
         div_q     <= div_d;
         rdata_q   <= rdata_d;
         rx_ie_q   <= rx_ie_d;
         tx_ie_q   <= tx_ie_d;
      end
   end

`ifdef UART_CTRL_IRQ_EN
   logic irq_q;
   logic unused_wd;
   assign unused_wd = ^avs_writedata[31:18];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_q <= 1'b0;
      else          irq_q <= (rx_full_q & rx_ie_q) | (!tx_full_q & tx_ie_q);
   end

   assign irq = irq_q;
`else
   logic unused_wd;
   assign unused_wd = ^{avs_writedata[31:16], rx_ie_d, tx_ie_d};
`endif

   uart_baud_gen #(
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_baud (
      .clk      (clk),
      .reset_n  (reset_n),
      .div_i    (div_d),
      .reload_i (wr_ctrl),
      .tick_o   (baud_tick)
   );

   assign avs_readdata  = rdata_q;
   assign core_tx_valid = tx_full_q;
   assign core_tx_data  = tx_hold_q;

endmodule

// File: tb/tb_uart_avmm_ctrl.sv
// Self-checking bench for uart_avmm_ctrl: directed register scenarios and
// randomized traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_uart_avmm_ctrl;

   localparam logic [15:0] DDIV = 16'd26;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        core_tx_valid;
   logic        core_tx_ready = 1'b0;
   logic [7:0]  core_tx_data;
   logic        core_rx_valid = 1'b0;
   logic [7:0]  core_rx_data = '0;
   logic        baud_tick;
   logic        irq;

`ifndef UART_CTRL_IRQ_EN
   assign irq = 1'b0;
`endif

   uart_avmm_ctrl #(.DEFAULT_DIV(DDIV)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
`ifdef UART_CTRL_IRQ_EN
      .irq           (irq),
`endif
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .core_tx_valid (core_tx_valid),
      .core_tx_ready (core_tx_ready),
      .core_tx_data  (core_tx_data),
      .core_rx_valid (core_rx_valid),
      .core_rx_data  (core_rx_data),
      .baud_tick     (baud_tick)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endfunction

   // Behavioural model: state as visible during the current cycle.
   logic        m_rxf, m_txf, m_ovr, m_drop, m_rxie, m_txie, m_irq;
   logic        m_rdv, m_tk;
   logic [7:0]  m_rxb, m_txb;
   logic [15:0] m_div;
   logic [31:0] m_rd;
   int          cyc = 0;
   int          nxt_tick = 0;

   always @(negedge clk) begin : model
      logic hs, rdrx, wtx, wst, wctl, irq_n;
      if (!reset_n) begin
         m_rxf = 0; m_txf = 0; m_ovr = 0; m_drop = 0;
         m_rxie = 0; m_txie = 0; m_irq = 0; m_rdv = 0; m_tk = 0;
         m_rxb = 0; m_txb = 0; m_div = DDIV; m_rd = 0;
         chk("rst_rdata", avs_readdata, 0);
         chk("rst_txv", core_tx_valid, 0);
         chk("rst_txd", core_tx_data, 0);
         chk("rst_tick", baud_tick, 0);
         chk("rst_irq", irq, 0);
      end else begin
         chk("tx_valid", core_tx_valid, m_txf);
         chk("tx_data", core_tx_data, m_txb);
         if (m_rdv) chk("rdata", avs_readdata, m_rd);
         if (m_tk) chk("tick", baud_tick, cyc == nxt_tick);
         chk("irq", irq, m_irq);

         hs    = m_txf && core_tx_ready;
         rdrx  = avs_read && avs_address == 2'd0;
         wtx   = avs_write && avs_address == 2'd1;
         wst   = avs_write && avs_address == 2'd2;
         wctl  = avs_write && avs_address == 2'd3;
         irq_n = (m_rxf && m_rxie) || (!m_txf && m_txie);

         m_rdv = avs_read;
         if (avs_read) begin
            case (avs_address)
               2'd0: m_rd = {24'b0, m_rxb};
               2'd1: m_rd = 0;
               2'd2: m_rd = {28'b0, m_drop, m_ovr, !m_txf, m_rxf};
               default: m_rd = {14'b0, m_txie, m_rxie, m_div};
            endcase
         end

         if (wctl) begin
            nxt_tick = cyc + int'(avs_writedata[15:0]) + 2;
            m_tk = 1;
         end else if (m_tk && cyc == nxt_tick) begin
            nxt_tick = cyc + int'(m_div) + 1;
         end

         if (wst && avs_writedata[2]) m_ovr = 0;
         if (wst && avs_writedata[3]) m_drop = 0;

         if (wtx) begin
            if (!m_txf || hs) begin
               m_txb = avs_writedata[7:0];
               m_txf = 1;
            end else m_drop = 1;
         end else if (hs) m_txf = 0;

         if (core_rx_valid) begin
            if (!m_rxf || rdrx) begin
               m_rxb = core_rx_data;
               m_rxf = 1;
            end else m_ovr = 1;
         end else if (rdrx) m_rxf = 0;

         if (wctl) begin
            m_div = avs_writedata[15:0];
`ifdef UART_CTRL_IRQ_EN
            m_rxie = avs_writedata[16];
            m_txie = avs_writedata[17];
`endif
         end
         m_irq = irq_n;
      end
      cyc++;
   end

   task automatic step(input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
      avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
      @(posedge clk); #1;
      avs_read = 0; avs_write = 0; core_rx_valid = 0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
      step(1, 0, a, 0);
      v = avs_readdata;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
      step(0, 1, a, wd);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      core_rx_valid = 1; core_rx_data = b;
      step(0, 0, 0, 0);
   endtask

   initial begin : drive
      logic [31:0] v;
      int t[$];
      logic [1:0] a;
      logic r, w;
      logic [31:0] wd;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_lit_txv", core_tx_valid, 0);
      chk("rst_lit_rd", avs_readdata, 0);
      reset_n = 1;

      rd_reg(2, v); chk("status_reset", v, 32'h2);
      rd_reg(3, v); chk("ctrl_reset", v, 32'h1A);

      wr_reg(3, 32'h3);
      for (int i = 0; i < 30; i++) begin
         if (baud_tick) t.push_back(i);
         step(0, 0, 0, 0);
      end
      chk("baud_nticks", t.size() >= 6, 1);
      if (t.size() > 0) chk("baud_first", t[0], 4);
      for (int k = 0; k + 1 < t.size(); k++)
         chk("baud_gap", t[k+1] - t[k], 4);

      core_tx_ready = 0;
      wr_reg(1, 32'h55);
      chk("tx_valid_lit", core_tx_valid, 1);
      chk("tx_data_lit", core_tx_data, 8'h55);
      wr_reg(1, 32'hAA);
      chk("tx_keep_lit", core_tx_data, 8'h55);
      rd_reg(2, v); chk("status_drop", v, 32'h8);
      core_tx_ready = 1;
      step(0, 0, 0, 0);
      core_tx_ready = 0;
      chk("tx_done_lit", core_tx_valid, 0);
      rd_reg(2, v); chk("status_empty_drop", v, 32'hA);
      wr_reg(2, 32'h8);
      rd_reg(2, v); chk("status_drop_clr", v, 32'h2);

      rx_pulse(8'h41);
      rx_pulse(8'h42);
      rd_reg(0, v); chk("rx_first", v, 32'h41);
      rd_reg(2, v); chk("status_ovr", v, 32'h6);
      wr_reg(2, 32'h4);
      rd_reg(2, v); chk("status_ovr_clr", v, 32'h2);

      rx_pulse(8'h41);
      core_rx_valid = 1; core_rx_data = 8'h43;
      rd_reg(0, v); chk("rx_coincide_old", v, 32'h41);
      rd_reg(2, v); chk("status_full_kept", v, 32'h3);
      rd_reg(0, v); chk("rx_coincide_new", v, 32'h43);

`ifdef UART_CTRL_IRQ_EN
      wr_reg(3, 32'h10003);
      rx_pulse(8'h10);
      chk("irq_n1", irq, 0);
      step(0, 0, 0, 0);
      chk("irq_n2", irq, 1);
      rd_reg(0, v); chk("irq_rxdata", v, 32'h10);
      chk("irq_m1", irq, 1);
      step(0, 0, 0, 0);
      chk("irq_m2", irq, 0);
`endif

      for (int i = 0; i < 4000; i++) begin
         a  = 2'($urandom_range(0, 3));
         r  = ($urandom_range(0, 2) == 0);
         w  = ($urandom_range(0, 3) == 0);
         wd = $urandom;
         if (a == 2'd3) begin
            wd = wd & 32'h0003_0007;
            if ($urandom_range(0, 7) != 0) w = 0;
         end
         core_tx_ready = ($urandom_range(0, 3) == 0);
         core_rx_valid = ($urandom_range(0, 4) == 0);
         core_rx_data  = 8'($urandom);
         step(r, w, a, wd);
      end

      core_tx_ready = 1;
      step(0, 0, 0, 0);
      core_tx_ready = 0;
      wr_reg(1, 32'h77);
      chk("pre_rst_txv", core_tx_valid, 1);
      @(posedge clk); #3;
      reset_n = 0;
      #1;
      chk("mid_rst_txv", core_tx_valid, 0);
      chk("mid_rst_txd", core_tx_data, 0);
      chk("mid_rst_tick", baud_tick, 0);
      @(posedge clk); #1;
      reset_n = 1;
      rd_reg(2, v); chk("post_rst_status", v, 32'h2);
      rd_reg(3, v); chk("post_rst_ctrl", v, 32'h1A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_avmm_ctrl.md
# uart_avmm_ctrl

Avalon-MM slave controller that configures and sequences one `uart_core` instance. It exposes a four-register CPU interface and generates the 16x oversampling baud tick from a programmable divisor. It buffers one TX byte and one RX byte, and drives the core's TX valid/ready handshake. It sits between the Avalon interconnect and `uart_core` inside the UART slave.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd26: baud divisor loaded at reset. Tick period = DIV+1 clocks.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock.
  - `reset_n`  in  1  asynchronous, active-low reset.
- Avalon-MM slave (fixed read latency 1, no waitrequest):
  - `avs_address`  in  2  word address.
  - `avs_read`  in  1  read strobe.
  - `avs_write`  in  1  write strobe.
  - `avs_writedata`  in  32  write data.
  - `avs_readdata`  out  32  read data, valid the cycle after `avs_read`.
- Core TX handshake:
  - `core_tx_valid`  out  1  TX holding register full.
  - `core_tx_ready`  in  1  core accepts byte.
  - `core_tx_data`  out  8  byte to transmit.
- Core RX handshake:
  - `core_rx_valid`  in  1  one-cycle pulse, received byte available.
  - `core_rx_data`  in  8  received byte.
- Timing and interrupt:
  - `baud_tick`  out  1  one-cycle oversample strobe to core.
  - `irq`  out  1  interrupt, level, registered (only with `UART_CTRL_IRQ_EN`).

## Operation
- Register map (word addresses):
  - 0 RXDATA: read returns `{24'b0, rx_hold}` and clears RX_FULL. Writes are ignored.
  - 1 TXDATA: write loads `avs_writedata[7:0]` into `tx_hold`. Reads return 0.
  - 2 STATUS:
    - bit0 RX_FULL.
    - bit1 TX_EMPTY.
    - bit2 RX_OVR (sticky).
    - bit3 TX_DROP (sticky).
    - Writing 1 to bit2 or bit3 clears that bit. Other bits are read-only.
  - 3 CTRL:
    - [15:0] DIV.
    - [16] RX_IE.
    - [17] TX_IE.
    - Read returns the current values. Other bits read 0.
- TX path:
  - `core_tx_valid` = tx_full.
  - Handshake completes on `core_tx_valid && core_tx_ready` and clears tx_full.
  - A TXDATA write while tx_full, with no handshake that cycle, is dropped and sets TX_DROP. `tx_hold` is unchanged.
  - A TXDATA write in the same cycle as a completing handshake is accepted. tx_full stays 1 and holds the new byte.
  - `core_tx_data` is stable while `core_tx_valid` is high.
- RX path:
  - `core_rx_valid` with RX_FULL=0: store the byte and set RX_FULL.
  - `core_rx_valid` with RX_FULL=1 and no RXDATA read that cycle: discard the new byte, keep the old one, and set RX_OVR.
  - `core_rx_valid` coinciding with an RXDATA read: the read returns the old byte. The new byte is stored and RX_FULL stays 1.
- Baud generator:
  - Down-counter from DIV. `baud_tick`=1 for one cycle when the count is 0, then the counter reloads to DIV.
  - DIV=0 gives a tick every cycle.
  - A CTRL write reloads the counter to the new DIV next cycle, with no tick that cycle.
- Write and read to the same address in the same cycle: the read returns pre-write state.

## Timing
- Reset values:
  - `avs_readdata`=0.
  - `core_tx_valid`=0, `core_tx_data`=0.
  - `baud_tick`=0.
  - `irq`=0.
  - DIV=DEFAULT_DIV, counter=DEFAULT_DIV.
  - RX_IE=TX_IE=0.
  - All status flags 0, with TX_EMPTY reading 1.
- Read latency is exactly 1 cycle. The RX_FULL clear is visible in STATUS on the cycle after the RXDATA read.
- TXDATA write at cycle N: `core_tx_valid`=1 at N+1.
- RX byte pulse at N: RX_FULL=1 readable by a read issued at N+1.
- Reset asserted mid-operation: all state clears immediately. A byte held in `tx_hold` is lost. The core is responsible for aborting its frame.

## Configuration
- `UART_CTRL_IRQ_EN` defined:
  - `irq` port present.
  - `irq` registered as `(RX_FULL & RX_IE) | (!tx_full & TX_IE)`. It updates 1 cycle after its inputs change.
- `UART_CTRL_IRQ_EN` undefined:
  - No `irq` port.
  - CTRL[17:16] are not stored and read 0.

## Structure
- Shared package `uart_pkg`:
  - register address constants (`UART_ADDR_RXDATA`..`UART_ADDR_CTRL`);
  - STATUS bit index constants;
  - the CTRL field width constant.
- One sub-module, `uart_baud_gen`: the DIV counter and tick, with inputs for DIV and reload.
- Register file, TX and RX holding registers and irq logic stay in the top module.

## Test plan
- Reset, then read STATUS → 0x2. Read CTRL → DEFAULT_DIV (0x1A).
- Write CTRL=0x3 and count clocks between `baud_tick` pulses → exactly 4 clocks apart, steady.
- Write TXDATA=0x55 with `core_tx_ready`=0:
  - → `core_tx_valid`=1, data 0x55.
  - A second write of 0xAA → TX_DROP=1, data remains 0x55.
  - Ready=1 for one cycle → valid drops. STATUS bit1=1.
- Pulse `core_rx_valid` with 0x41, then with 0x42 before any read:
  - → RXDATA reads 0x41.
  - STATUS reads 0x6 (RX_OVR, TX_EMPTY).
  - Writing STATUS 0x4 clears RX_OVR.
- Issue an RXDATA read in the same cycle as a `core_rx_valid` pulse of 0x43, with 0x41 held:
  - → readdata 0x41.
  - RX_FULL stays 1. Next RXDATA read returns 0x43.
- With `UART_CTRL_IRQ_EN`:
  - Set RX_IE, then inject byte 0x10 → `irq`=1 two cycles after the pulse.
  - Read RXDATA → `irq`=0 two cycles after the read.
